pipeline_hazard_ctrl: RTL

- Central stall/flush sequencer for the in-order core pipeline.
- Merges per-stage stall requests and branch/exception flush requests into per-stage stall and flush vectors. These vectors drive every pipeline register's current-stage stall, next-stage stall and flush inputs.
- Sequences exception recovery: drains the store buffer, flushes, then redirects fetch.
- Exports a saturating stall-cycle performance counter.

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the recovery FSM state encoding, the stage index constants of the
// in-order core (fetch = 0 .. writeback/commit = 4) and the default depth.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;

    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;

    localparam int DEFAULT_STAGES = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk_i  clock
//   clr_i  synchronous active-high clear (wins over enable)
//   en_i   count enable; the count sticks at all ones once reached
//   cnt_o  current count
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the in-order core pipeline.
// Merges per-stage stall requests with branch and exception flushes into
// per-stage stall/flush vectors, sequences exception recovery
// (drain store buffer -> flush -> redirect fetch) and counts stall cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall_req                per-stage "cannot advance" requests
//   br_flush/br_stage/br_pc  mispredict: resolving stage and correct target
//   exc_flush/exc_pc         exception at commit and handler address
//   drain_done               store buffer is empty
//   stall, flush             per-stage hold / kill vectors
//   redirect_valid/_pc       one-cycle fetch redirect
//   busy                     recovery sequence in progress
//   drain_timeout            sticky: drain gave up waiting for the store buffer
//   stall_cycles             saturating count of cycles with fetch stalled
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int STAGES        = DEFAULT_STAGES,
    parameter int ADDR_WIDTH    = 32,
    parameter int DRAIN_TIMEOUT = 255,
    parameter int CNT_WIDTH     = 32,
    localparam int SW           = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STAGES-1:0]     stall_req,
    input  logic                  br_flush,
    input  logic [SW-1:0]         br_stage,
    input  logic [ADDR_WIDTH-1:0] br_pc,
    input  logic                  exc_flush,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic                  drain_done,
    output logic [STAGES-1:0]     stall,
    output logic [STAGES-1:0]     flush,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  busy,
    output logic                  drain_timeout,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    hz_state_e             state_q, state_d;
    logic [STAGES-1:0]     mask_q;
    logic [ADDR_WIDTH-1:0] target_q;
    logic                  timeout_q;

    logic [TW-1:0]         drain_timer;
    logic                  timer_expire;
    logic [STAGES-1:0]     stall_idle;

    // Mask killing every stage younger than the resolving one: bits [n-1:0].
    function automatic logic [STAGES-1:0] low_mask(input logic [SW-1:0] n);
        logic [STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < STAGES; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

    // A blocked stage must also freeze every younger (lower-index) stage,
    // otherwise those would overwrite its input register.
    always_comb begin
        stall_idle = '0;
        for (int i = 0; i < STAGES; i++) begin
            stall_idle[i] = |(stall_req >> i);
        end
    end

    // Timer value k means k+1 DRAIN cycles have elapsed by the coming edge.
    assign timer_expire = (drain_timer == TW'(DRAIN_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (exc_flush) begin
                    state_d = drain_done ? FLUSH : DRAIN;
                end else if (br_flush) begin
                    state_d = FLUSH;
                end
            end
            DRAIN: begin
                if (drain_done || timer_expire) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flush mask and redirect target are captured when the request is
    // accepted; an exception always takes priority over a branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q    <= '0;
            target_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (exc_flush) begin
                        mask_q   <= '1;
                        target_q <= exc_pc;
                    end else if (br_flush) begin
                        mask_q   <= low_mask(br_stage);
                        target_q <= br_pc;
                    end
                end
                DRAIN: begin
                    mask_q <= '1;
                    if (!drain_done && timer_expire) begin
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall          = '0;
        flush          = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            IDLE:  stall = stall_idle;
            DRAIN: stall = '1;
            FLUSH: begin
                flush          = mask_q;
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
            end
            default: ;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign drain_timeout = timeout_q;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .en_i  (stall[STAGE_IF]),
        .cnt_o (stall_cycles)
    );

    // Cleared whenever we are not draining so each DRAIN visit starts at 0.
    sat_counter #(
        .WIDTH (TW)
    ) u_drain_timer (
        .clk_i (clk),
        .clr_i (rst || (state_q != DRAIN)),
        .en_i  (state_q == DRAIN),
        .cnt_o (drain_timer)
    );

endmodule
